// File: rtl/rf_write_arbiter.sv
// Arbitrates the register-file write port between writeback (primary) and a
// buffered long-latency unit (auxiliary), with starvation forcing and a pending mask.
module rf_write_arbiter #(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 5,
  parameter int FIFO_DEPTH   = 4,
  parameter int STARVE_LIMIT = 3
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            wb_valid,
  input  logic [ADDR_W-1:0]               wb_rd,
  input  logic [DATA_W-1:0]               wb_data,
  output logic                            wb_stall,
  input  logic                            aux_valid,
  input  logic [ADDR_W-1:0]               aux_rd,
  input  logic [DATA_W-1:0]               aux_data,
  output logic                            aux_ready,
  output logic                            rf_we,
  output logic [ADDR_W-1:0]               rf_rd,
  output logic [DATA_W-1:0]               rf_wdata,
  output logic [(2**ADDR_W)-1:0]          pend_mask,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int NREG  = 2 ** ADDR_W;
  localparam int SC_W  = ($clog2(STARVE_LIMIT + 1) < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
  localparam logic [SC_W-1:0]  LIMIT_C = SC_W'(STARVE_LIMIT);

  logic [ADDR_W-1:0]     r_fifo_rd   [FIFO_DEPTH];
  logic [DATA_W-1:0]     r_fifo_data [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] r_fifo_vld;
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [CNT_W-1:0]      r_count;
  logic [SC_W-1:0]       r_starve;
  logic                  r_rf_we;
  logic [ADDR_W-1:0]     r_rf_rd;
  logic [DATA_W-1:0]     r_rf_wdata;

  logic                  w_wb_req;
  logic                  w_fifo_ne;
  logic                  w_grant_wb;
  logic                  w_grant_fifo;
  logic                  w_enq;
  logic [NREG-1:0]       w_pend;

  assign w_wb_req     = wb_valid && (wb_rd != '0);
  assign w_fifo_ne    = (r_count != '0);
  // Grants are masked by reset so nothing is registered or dequeued during reset.
  assign w_grant_wb   = rst && w_wb_req && (!w_fifo_ne || (r_starve < LIMIT_C));
  assign w_grant_fifo = rst && w_fifo_ne && (!w_wb_req || (r_starve == LIMIT_C));
  assign wb_stall     = rst && w_wb_req && !w_grant_wb;
  assign aux_ready    = rst && (r_count < DEPTH_C);
  assign w_enq        = aux_valid && aux_ready && (aux_rd != '0);

  always_comb begin
    w_pend = '0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (r_fifo_vld[i]) w_pend[r_fifo_rd[i]] = 1'b1;
    end
    pend_mask = rst ? w_pend : '0;
  end

  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_fifo_rd[r_wr_ptr]   <= aux_rd;
      r_fifo_data[r_wr_ptr] <= aux_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_fifo_vld <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_starve   <= '0;
      r_rf_we    <= 1'b0;
      r_rf_rd    <= '0;
      r_rf_wdata <= '0;
    end else begin
      // Enqueue and dequeue never hit the same slot: one needs empty, the other full.
      if (w_enq) begin
        r_fifo_vld[r_wr_ptr] <= 1'b1;
        r_wr_ptr             <= r_wr_ptr + PTR_W'(1);
      end
      if (w_grant_fifo) begin
        r_fifo_vld[r_rd_ptr] <= 1'b0;
        r_rd_ptr             <= r_rd_ptr + PTR_W'(1);
      end

      case ({w_enq, w_grant_fifo})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase

      if (w_grant_fifo || !w_fifo_ne)       r_starve <= '0;
      else if (w_grant_wb && r_starve != LIMIT_C) r_starve <= r_starve + SC_W'(1);

      r_rf_we <= w_grant_wb || w_grant_fifo;
      if (w_grant_wb) begin
        r_rf_rd    <= wb_rd;
        r_rf_wdata <= wb_data;
      end else if (w_grant_fifo) begin
        r_rf_rd    <= r_fifo_rd[r_rd_ptr];
        r_rf_wdata <= r_fifo_data[r_rd_ptr];
      end
    end
  end

  assign rf_we      = r_rf_we;
  assign rf_rd      = r_rf_rd;
  assign rf_wdata   = r_rf_wdata;
  assign fifo_count = r_count;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter: reset, primary path, aux latency/mask,
// starvation forcing, full FIFO drain and reset with queued entries.
module tb_rf_write_arbiter;

  logic        clk;
  logic        rst;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        wb_stall;
  logic        aux_valid;
  logic [4:0]  aux_rd;
  logic [31:0] aux_data;
  logic        aux_ready;
  logic        rf_we;
  logic [4:0]  rf_rd;
  logic [31:0] rf_wdata;
  logic [31:0] pend_mask;
  logic [2:0]  fifo_count;

  int n_cmp;
  int n_err;

  rf_write_arbiter #(.DATA_W(32), .ADDR_W(5), .FIFO_DEPTH(4), .STARVE_LIMIT(3)) dut (
    .clk(clk), .rst(rst),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .wb_stall(wb_stall),
    .aux_valid(aux_valid), .aux_rd(aux_rd), .aux_data(aux_data), .aux_ready(aux_ready),
    .rf_we(rf_we), .rf_rd(rf_rd), .rf_wdata(rf_wdata),
    .pend_mask(pend_mask), .fifo_count(fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; wb_valid = 1'b1; wb_rd = 5'd5; wb_data = 32'h55;
    aux_valid = 1'b1; aux_rd = 5'd4; aux_data = 32'h44;
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++; if (aux_ready !== 1'b0) begin n_err++; $display("FAIL rst_aux_ready: got %0b want 0", aux_ready); end
      n_cmp++; if (wb_stall !== 1'b0) begin n_err++; $display("FAIL rst_wb_stall: got %0b want 0", wb_stall); end
      n_cmp++; if (rf_we !== 1'b0) begin n_err++; $display("FAIL rst_rf_we: got %0b want 0", rf_we); end
      n_cmp++; if (fifo_count !== 3'd0) begin n_err++; $display("FAIL rst_count: got %0d want 0", fifo_count); end
      n_cmp++; if (pend_mask !== 32'h0) begin n_err++; $display("FAIL rst_pend: got %h want 0", pend_mask); end
    end
    n_cmp++; if (rf_rd !== 5'd0 || rf_wdata !== 32'h0) begin n_err++; $display("FAIL rst_rf_regs: got rd=%0d data=%h want 0/0", rf_rd, rf_wdata); end
    wb_valid = 1'b0; aux_valid = 1'b0; rst = 1'b1;
    #1;
    n_cmp++; if (aux_ready !== 1'b1) begin n_err++; $display("FAIL rst_release_ready: got %0b want 1", aux_ready); end
    step();
  endtask

  task automatic test_primary();
    wb_valid = 1'b1; wb_rd = 5'd5; wb_data = 32'hDEADBEEF;
    #1;
    n_cmp++; if (wb_stall !== 1'b0) begin n_err++; $display("FAIL prim_stall: got %0b want 0", wb_stall); end
    step();
    n_cmp++; if (rf_we !== 1'b1) begin n_err++; $display("FAIL prim_we: got %0b want 1", rf_we); end
    n_cmp++; if (rf_rd !== 5'd5) begin n_err++; $display("FAIL prim_rd: got %0d want 5", rf_rd); end
    n_cmp++; if (rf_wdata !== 32'hDEADBEEF) begin n_err++; $display("FAIL prim_data: got %h want deadbeef", rf_wdata); end
    wb_rd = 5'd0; wb_data = 32'h1234;
    #1;
    n_cmp++; if (wb_stall !== 1'b0) begin n_err++; $display("FAIL x0_stall: got %0b want 0", wb_stall); end
    step();
    n_cmp++; if (rf_we !== 1'b0) begin n_err++; $display("FAIL x0_we: got %0b want 0", rf_we); end
    n_cmp++; if (rf_rd !== 5'd5 || rf_wdata !== 32'hDEADBEEF) begin n_err++; $display("FAIL x0_hold: got rd=%0d data=%h want 5/deadbeef", rf_rd, rf_wdata); end
    wb_valid = 1'b0;
    step();
  endtask

  task automatic test_aux_latency();
    aux_valid = 1'b1; aux_rd = 5'd7; aux_data = 32'h12;
    #1;
    n_cmp++; if (aux_ready !== 1'b1) begin n_err++; $display("FAIL aux_ready: got %0b want 1", aux_ready); end
    step();
    aux_valid = 1'b0;
    #1;
    n_cmp++; if (pend_mask !== 32'h80) begin n_err++; $display("FAIL aux_pend_set: got %h want 00000080", pend_mask); end
    n_cmp++; if (fifo_count !== 3'd1) begin n_err++; $display("FAIL aux_count: got %0d want 1", fifo_count); end
    n_cmp++; if (rf_we !== 1'b0) begin n_err++; $display("FAIL aux_early_we: got %0b want 0", rf_we); end
    step();
    n_cmp++; if (rf_we !== 1'b1 || rf_rd !== 5'd7 || rf_wdata !== 32'h12) begin n_err++; $display("FAIL aux_write: got we=%0b rd=%0d data=%h want 1/7/12", rf_we, rf_rd, rf_wdata); end
    n_cmp++; if (pend_mask !== 32'h0) begin n_err++; $display("FAIL aux_pend_clr: got %h want 0", pend_mask); end
    step();
    n_cmp++; if (rf_we !== 1'b0) begin n_err++; $display("FAIL aux_after_we: got %0b want 0", rf_we); end
  endtask

  task automatic test_starvation();
    aux_valid = 1'b1; aux_rd = 5'd3; aux_data = 32'h33;
    step();
    aux_valid = 1'b0; wb_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wb_rd = 5'(10 + k); wb_data = 32'hA0 + 32'(k);
      #1;
      n_cmp++; if (wb_stall !== 1'b0) begin n_err++; $display("FAIL starve_stall%0d: got %0b want 0", k, wb_stall); end
      step();
      n_cmp++; if (rf_we !== 1'b1 || rf_rd !== 5'(10 + k)) begin n_err++; $display("FAIL starve_prim%0d: got we=%0b rd=%0d want 1/%0d", k, rf_we, rf_rd, 10 + k); end
    end
    wb_rd = 5'd13; wb_data = 32'hA3;
    #1;
    n_cmp++; if (wb_stall !== 1'b1) begin n_err++; $display("FAIL starve_force: got %0b want 1", wb_stall); end
    step();
    n_cmp++; if (rf_we !== 1'b1 || rf_rd !== 5'd3 || rf_wdata !== 32'h33) begin n_err++; $display("FAIL starve_aux: got we=%0b rd=%0d data=%h want 1/3/33", rf_we, rf_rd, rf_wdata); end
    n_cmp++; if (wb_stall !== 1'b0) begin n_err++; $display("FAIL starve_resume_stall: got %0b want 0", wb_stall); end
    step();
    n_cmp++; if (rf_we !== 1'b1 || rf_rd !== 5'd13 || rf_wdata !== 32'hA3) begin n_err++; $display("FAIL starve_resume: got we=%0b rd=%0d data=%h want 1/13/a3", rf_we, rf_rd, rf_wdata); end
    wb_valid = 1'b0;
    step();
  endtask

  task automatic test_full_fifo();
    wb_valid = 1'b1; wb_rd = 5'd20; wb_data = 32'h2020;
    for (int k = 0; k < 4; k++) begin
      aux_valid = 1'b1; aux_rd = 5'(k + 1); aux_data = 32'h100 + 32'(k + 1);
      #1;
      n_cmp++; if (aux_ready !== 1'b1) begin n_err++; $display("FAIL full_ready%0d: got %0b want 1", k, aux_ready); end
      step();
    end
    wb_valid = 1'b0; aux_rd = 5'd9; aux_data = 32'h999;
    #1;
    n_cmp++; if (fifo_count !== 3'd4) begin n_err++; $display("FAIL full_count: got %0d want 4", fifo_count); end
    n_cmp++; if (aux_ready !== 1'b0) begin n_err++; $display("FAIL full_ready: got %0b want 0", aux_ready); end
    n_cmp++; if (pend_mask !== 32'h1E) begin n_err++; $display("FAIL full_pend: got %h want 0000001e", pend_mask); end
    step();
    aux_valid = 1'b0;
    #1;
    n_cmp++; if (rf_we !== 1'b1 || rf_rd !== 5'd1 || rf_wdata !== 32'h101) begin n_err++; $display("FAIL drain0: got we=%0b rd=%0d data=%h want 1/1/101", rf_we, rf_rd, rf_wdata); end
    n_cmp++; if (fifo_count !== 3'd3) begin n_err++; $display("FAIL no_passthru: got %0d want 3", fifo_count); end
    n_cmp++; if (aux_ready !== 1'b1) begin n_err++; $display("FAIL full_ready_back: got %0b want 1", aux_ready); end
    for (int k = 1; k < 4; k++) begin
      step();
      n_cmp++; if (rf_we !== 1'b1 || rf_rd !== 5'(k + 1) || rf_wdata !== 32'h100 + 32'(k + 1)) begin n_err++; $display("FAIL drain%0d: got we=%0b rd=%0d data=%h want 1/%0d/%h", k, rf_we, rf_rd, rf_wdata, k + 1, 32'h100 + 32'(k + 1)); end
    end
    step();
    n_cmp++; if (rf_we !== 1'b0 || fifo_count !== 3'd0) begin n_err++; $display("FAIL drain_done: got we=%0b count=%0d want 0/0", rf_we, fifo_count); end
  endtask

  task automatic test_reset_mid_queue();
    wb_valid = 1'b1; wb_rd = 5'd21; wb_data = 32'h2121;
    for (int k = 0; k < 3; k++) begin
      aux_valid = 1'b1; aux_rd = 5'(k + 11); aux_data = 32'h500 + 32'(k);
      step();
    end
    aux_valid = 1'b0;
    #1;
    n_cmp++; if (fifo_count !== 3'd3) begin n_err++; $display("FAIL midrst_count_pre: got %0d want 3", fifo_count); end
    n_cmp++; if (pend_mask !== 32'h3800) begin n_err++; $display("FAIL midrst_pend_pre: got %h want 00003800", pend_mask); end
    rst = 1'b0;
    step();
    rst = 1'b1; wb_valid = 1'b0;
    #1;
    n_cmp++; if (fifo_count !== 3'd0) begin n_err++; $display("FAIL midrst_count: got %0d want 0", fifo_count); end
    n_cmp++; if (pend_mask !== 32'h0) begin n_err++; $display("FAIL midrst_pend: got %h want 0", pend_mask); end
    n_cmp++; if (rf_we !== 1'b0) begin n_err++; $display("FAIL midrst_we: got %0b want 0", rf_we); end
    for (int k = 0; k < 3; k++) begin
      step();
      n_cmp++; if (rf_we !== 1'b0) begin n_err++; $display("FAIL midrst_no_we%0d: got %0b want 0", k, rf_we); end
    end
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    rst = 1'b0; wb_valid = 1'b0; wb_rd = '0; wb_data = '0;
    aux_valid = 1'b0; aux_rd = '0; aux_data = '0;
    test_reset();
    test_primary();
    test_aux_latency();
    test_starvation();
    test_full_fifo();
    test_reset_mid_queue();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
